// File: rtl/uart_interrupts_if.sv
// Interrupt controller bus: configuration and status in,
// resolved ISR value and interrupt line out.
interface uart_interrupts_if #(
   parameter int FifoDepth = 16
);
   localparam int CntW = $clog2(FifoDepth) + 1;

   logic [3:0]      ier_i;
   logic            fifo_en_i;
   logic [1:0]      rx_trigger_i;
   logic [CntW-1:0] rx_count_i;
   logic            rx_push_i;
   logic            rx_pop_i;
   logic            char_tick_i;
   logic [3:0]      lsr_err_i;
   logic            thr_empty_i;
   logic            write_thr_i;
   logic            read_isr_i;
   logic [3:0]      msr_delta_i;
   logic [7:0]      isr_o;
   logic            isr_valid_o;
   logic            irq_o;

   modport master (
      output ier_i, fifo_en_i, rx_trigger_i, rx_count_i,
      output rx_push_i, rx_pop_i, char_tick_i, lsr_err_i,
      output thr_empty_i, write_thr_i, read_isr_i, msr_delta_i,
      input  isr_o, isr_valid_o, irq_o
   );

   modport slave (
      input  ier_i, fifo_en_i, rx_trigger_i, rx_count_i,
      input  rx_push_i, rx_pop_i, char_tick_i, lsr_err_i,
      input  thr_empty_i, write_thr_i, read_isr_i, msr_delta_i,
      output isr_o, isr_valid_o, irq_o
   );
endinterface

// File: rtl/uart_interrupts.sv
// 16550-style interrupt resolver for the OBI UART, with the
// RX character-timeout counter and the THR-empty latch.
module uart_interrupts #(
   parameter int FifoDepth    = 16,
   parameter int TimeoutChars = 4
) (
   input logic              clk_i,
   input logic              rst_ni,
   uart_interrupts_if.slave bus
);
   localparam int CntW = $clog2(FifoDepth) + 1;
   localparam logic [2:0] ToMax = 3'(TimeoutChars);

   logic [CntW-1:0] cnt;
   logic [31:0] cnt_ext;
   logic [31:0] trig;
   logic [2:0] to_cnt_q, to_cnt_d;
   logic thre_q, thre_d;
   logic thr_empty_q, thr_empty_d;
   logic ier1_q, ier1_d;
   logic [7:0] isr_q, isr_d;
   logic isr_valid_q, isr_valid_d;
   logic irq_q, irq_d;
   logic ls, rda, cto, thre, ms, pend;
   logic [2:0] code;

   assign cnt     = bus.rx_count_i;
   assign cnt_ext = 32'(cnt);

   // Receive trigger level from FCR; single character without FIFO
   always_comb begin
      trig = 32'd1;
      if (bus.fifo_en_i) begin
         unique case (bus.rx_trigger_i)
            2'b00: trig = 32'd1;
            2'b01: trig = 32'd4;
            2'b10: trig = 32'd8;
            2'b11: trig = 32'd14;
         endcase
      end
   end

   // Timeout counter; FIFO activity or empty FIFO restarts it
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (bus.rx_push_i || bus.rx_pop_i || cnt == '0)
         to_cnt_d = 3'd0;
      else if (bus.char_tick_i && to_cnt_q != ToMax)
         to_cnt_d = to_cnt_q + 3'd1;
   end

   // THRE latch: set on empty/enable edges, clear wins over set
   always_comb begin
      logic set, clr;
      thr_empty_d = bus.thr_empty_i;
      ier1_d      = bus.ier_i[1];
      set = (bus.thr_empty_i && !thr_empty_q) ||
            (bus.ier_i[1] && !ier1_q && bus.thr_empty_i);
      clr = bus.write_thr_i ||
            (bus.read_isr_i && isr_q[3:0] == 4'b0010);
      thre_d = thre_q;
      if (clr)
         thre_d = 1'b0;
      else if (set)
         thre_d = 1'b1;
   end

   // Source resolution by priority into the next ISR value
   always_comb begin
      ls   = (|bus.lsr_err_i) && bus.ier_i[2];
      rda  = (cnt_ext >= trig) && bus.ier_i[0];
      cto  = (to_cnt_q == ToMax) && (cnt != '0) && bus.ier_i[0];
      thre = thre_q && bus.ier_i[1];
      ms   = (|bus.msr_delta_i) && bus.ier_i[3];
      pend = 1'b1;
      code = 3'b000;
      if (ls)
         code = 3'b011;
      else if (cto)
         code = 3'b110;
      else if (rda)
         code = 3'b010;
      else if (thre)
         code = 3'b001;
      else if (ms)
         code = 3'b000;
      else
         pend = 1'b0;
      isr_d = {{2{bus.fifo_en_i}}, 2'b00, code, ~pend};
      isr_valid_d = (isr_d != isr_q);
      irq_d = pend;
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt_q    <= 3'd0;
         thre_q      <= 1'b0;
         thr_empty_q <= 1'b0;
         ier1_q      <= 1'b0;
         isr_q       <= 8'h01;
         isr_valid_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         thre_q      <= thre_d;
         thr_empty_q <= thr_empty_d;
         ier1_q      <= ier1_d;
         isr_q       <= isr_d;
         isr_valid_q <= isr_valid_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.isr_o       = isr_q;
   assign bus.isr_valid_o = isr_valid_q;
   assign bus.irq_o       = irq_q;
endmodule

// File: tb/tb_uart_interrupts.sv
// Directed checks for the UART interrupt controller.
module tb_uart_interrupts;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int passed = 0;

   uart_interrupts_if #(.FifoDepth(16)) bus ();

   uart_interrupts #(.FifoDepth(16), .TimeoutChars(4)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk8(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic chk1(input string name, input logic act,
                       input logic exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %b expected %b", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         bus.char_tick_i = 1'b1;
         cyc(1);
         bus.char_tick_i = 1'b0;
      end
   endtask

   task automatic test_reset;
      cyc(2);
      chk8("reset_isr", bus.isr_o, 8'h01);
      chk1("reset_valid", bus.isr_valid_o, 1'b0);
      chk1("reset_irq", bus.irq_o, 1'b0);
   endtask

   task automatic test_thre;
      bus.thr_empty_i = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      chk8("thre_idle", bus.isr_o, 8'h01);
      bus.ier_i = 4'b0010;
      cyc(1);
      chk8("thre_set", bus.isr_o, 8'h02);
      chk1("thre_irq", bus.irq_o, 1'b1);
      chk1("thre_valid", bus.isr_valid_o, 1'b1);
      cyc(1);
      chk1("thre_valid_drop", bus.isr_valid_o, 1'b0);
      bus.read_isr_i = 1'b1;
      cyc(1);
      bus.read_isr_i = 1'b0;
      chk8("thre_read_value", bus.isr_o, 8'h02);
      cyc(1);
      chk8("thre_read_clr", bus.isr_o, 8'h01);
      chk1("thre_clr_valid", bus.isr_valid_o, 1'b1);
      chk1("thre_clr_irq", bus.irq_o, 1'b0);
      cyc(1);
      chk1("thre_clr_valid_drop", bus.isr_valid_o, 1'b0);
      bus.ier_i = 4'b0000;
      bus.thr_empty_i = 1'b0;
      cyc(1);
   endtask

   task automatic test_rda;
      bus.fifo_en_i = 1'b1;
      bus.rx_trigger_i = 2'b01;
      bus.ier_i = 4'b0001;
      cyc(1);
      chk8("rda_fifo_idle", bus.isr_o, 8'hC1);
      for (int i = 1; i <= 4; i++) begin
         bus.rx_count_i = 5'(i);
         bus.rx_push_i = 1'b1;
         cyc(1);
         bus.rx_push_i = 1'b0;
         chk8($sformatf("rda_push%0d", i), bus.isr_o,
              (i >= 4) ? 8'hC4 : 8'hC1);
      end
      bus.rx_count_i = 5'd3;
      bus.rx_pop_i = 1'b1;
      cyc(1);
      bus.rx_pop_i = 1'b0;
      chk8("rda_pop", bus.isr_o, 8'hC1);
   endtask

   task automatic test_timeout;
      bus.rx_count_i = 5'd2;
      cyc(1);
      tick_n(4);
      chk8("cto_not_yet", bus.isr_o, 8'hC1);
      cyc(1);
      chk8("cto_set", bus.isr_o, 8'hCC);
      tick_n(1);
      cyc(1);
      chk8("cto_saturate", bus.isr_o, 8'hCC);
      bus.rx_count_i = 5'd1;
      bus.rx_pop_i = 1'b1;
      cyc(1);
      bus.rx_pop_i = 1'b0;
      cyc(1);
      chk8("cto_pop_clear", bus.isr_o, 8'hC1);
      bus.rx_count_i = 5'd2;
      bus.rx_push_i = 1'b1;
      bus.char_tick_i = 1'b1;
      cyc(1);
      bus.rx_push_i = 1'b0;
      bus.char_tick_i = 1'b0;
      tick_n(3);
      cyc(2);
      chk8("cto_push_beats_tick", bus.isr_o, 8'hC1);
      tick_n(1);
      cyc(1);
      chk8("cto_fourth_tick", bus.isr_o, 8'hCC);
      bus.rx_count_i = 5'd0;
      cyc(1);
      chk8("cto_empty", bus.isr_o, 8'hC1);
      cyc(1);
   endtask

   task automatic test_priority;
      bus.ier_i = 4'b1111;
      bus.lsr_err_i = 4'b0001;
      bus.rx_count_i = 5'd4;
      bus.msr_delta_i = 4'b0010;
      bus.thr_empty_i = 1'b1;
      cyc(2);
      chk8("prio_ls", bus.isr_o, 8'hC6);
      bus.lsr_err_i = 4'b0000;
      cyc(1);
      chk8("prio_rda", bus.isr_o, 8'hC4);
      bus.rx_count_i = 5'd0;
      cyc(1);
      chk8("prio_thre", bus.isr_o, 8'hC2);
      bus.write_thr_i = 1'b1;
      cyc(1);
      bus.write_thr_i = 1'b0;
      cyc(1);
      chk8("prio_ms", bus.isr_o, 8'hC0);
      chk1("prio_ms_irq", bus.irq_o, 1'b1);
      bus.msr_delta_i = 4'b0000;
      cyc(1);
      chk8("prio_none", bus.isr_o, 8'hC1);
      chk1("prio_none_irq", bus.irq_o, 1'b0);
   endtask

   task automatic test_set_clr_same;
      bus.fifo_en_i = 1'b0;
      bus.thr_empty_i = 1'b0;
      cyc(2);
      chk8("sc_fifo_off", bus.isr_o, 8'h01);
      bus.thr_empty_i = 1'b1;
      bus.write_thr_i = 1'b1;
      cyc(1);
      bus.write_thr_i = 1'b0;
      cyc(2);
      chk8("sc_clear_wins", bus.isr_o, 8'h01);
      chk1("sc_no_valid", bus.isr_valid_o, 1'b0);
   endtask

   task automatic test_reset_mid;
      bus.fifo_en_i = 1'b1;
      bus.ier_i = 4'b0001;
      bus.thr_empty_i = 1'b0;
      bus.rx_count_i = 5'd2;
      cyc(1);
      tick_n(4);
      cyc(1);
      chk8("mid_cto", bus.isr_o, 8'hCC);
      rst_n = 1'b0;
      #1;
      chk8("mid_rst_isr", bus.isr_o, 8'h01);
      chk1("mid_rst_valid", bus.isr_valid_o, 1'b0);
      chk1("mid_rst_irq", bus.irq_o, 1'b0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      chk8("mid_after", bus.isr_o, 8'hC1);
      tick_n(3);
      cyc(2);
      chk8("mid_restart", bus.isr_o, 8'hC1);
      chk1("mid_restart_irq", bus.irq_o, 1'b0);
      tick_n(1);
      cyc(1);
      chk8("mid_threshold", bus.isr_o, 8'hCC);
   endtask

   initial begin
      bus.ier_i = 4'b0000;
      bus.fifo_en_i = 1'b0;
      bus.rx_trigger_i = 2'b00;
      bus.rx_count_i = 5'd0;
      bus.rx_push_i = 1'b0;
      bus.rx_pop_i = 1'b0;
      bus.char_tick_i = 1'b0;
      bus.lsr_err_i = 4'b0000;
      bus.thr_empty_i = 1'b0;
      bus.write_thr_i = 1'b0;
      bus.read_isr_i = 1'b0;
      bus.msr_delta_i = 4'b0000;
      test_reset;
      test_thre;
      test_rda;
      test_timeout;
      test_priority;
      test_set_clr_same;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
